// File: rtl/ofs_asp_pkg.sv
// ofs_asp_pkg: shared ASP interrupt constants, CSR offsets and interrupt FSM states.
package ofs_asp_pkg;
  localparam int ASP_NUM_INTERRUPT_LINES = 4;
  localparam int ASP_NUM_IRQ_USED = 3;
  localparam int ASP_DMA_0_IRQ = 0;
  localparam int ASP_KERNEL_IRQ = 1;
  localparam int ASP_DMA_1_IRQ = 2;
  localparam logic [2:0] ASP_IRQ_CSR_PENDING = 3'd0;
  localparam logic [2:0] ASP_IRQ_CSR_ENABLE = 3'd1;
  localparam logic [2:0] ASP_IRQ_CSR_ACTIVE = 3'd2;
  localparam logic [2:0] ASP_IRQ_CSR_COUNT = 3'd3;
  typedef enum logic [1:0] {ASP_IRQ_IDLE, ASP_IRQ_REQ, ASP_IRQ_WAIT_CLR} asp_irq_state_e;
endpackage

// File: rtl/asp_irq_rr_arbiter.sv
// asp_irq_rr_arbiter: combinational round-robin pick of the first request at or after the pointer.
module asp_irq_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);
  logic [N-1:0] w_rot;
  logic [W:0]   w_off;
  logic [W:0]   w_sum;
  // rotate so the pointer position lands at bit 0, then take the lowest set bit
  assign w_rot = N'({i_req, i_req} >> i_ptr);
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) if (w_rot[k]) w_off = (W+1)'(k);
  end
  assign w_sum   = {1'b0, i_ptr} + w_off;
  assign o_idx   = w_sum >= (W+1)'(N) ? W'(w_sum - (W+1)'(N)) : w_sum[W-1:0];
  assign o_valid = |i_req;
endmodule

// File: rtl/asp_irq_ctrl.sv
// asp_irq_ctrl: sticky edge-triggered interrupt collector with CSR access and one-at-a-time host request.
// Optional ack counter at COUNT is built only when ASP_IRQ_CTRL_COUNTERS_EN is defined.
module asp_irq_ctrl
  import ofs_asp_pkg::*;
#(
  parameter int NUM_LINES = ASP_NUM_INTERRUPT_LINES,
  parameter int NUM_USED  = ASP_NUM_IRQ_USED
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] irq_in,
  input  logic [2:0]           csr_address,
  input  logic                 csr_read,
  input  logic                 csr_write,
  input  logic [63:0]          csr_writedata,
  input  logic [7:0]           csr_byteenable,
  output logic [63:0]          csr_readdata,
  output logic                 csr_readdatavalid,
  output logic                 csr_waitrequest,
  output logic                 intr_req,
  output logic [1:0]           intr_id,
  input  logic                 intr_ack
);
  localparam logic [NUM_LINES-1:0] USED = NUM_LINES'((1 << NUM_USED) - 1);
  asp_irq_state_e       r_st, w_st_nxt;
  logic [NUM_LINES-1:0] r_irq, r_irq_d, r_pend, r_en;
  logic [NUM_LINES-1:0] w_rise, w_clr, w_act, w_id_oh;
  logic [1:0]           r_ptr, r_id, w_idx;
  logic [3:0]           w_inc;
  logic                 w_wr, w_ack, w_sel_valid, r_rdv;
  logic [31:0]          w_cnt;
  logic [63:0]          r_rdata, w_rdata;
  logic                 w_unused;
  assign w_unused = ^{csr_writedata, csr_byteenable[7:1]};
  assign w_wr     = csr_write & csr_byteenable[0];
  assign w_rise   = r_irq & ~r_irq_d;
  assign w_clr    = (w_wr && csr_address == ASP_IRQ_CSR_PENDING) ? csr_writedata[NUM_LINES-1:0] : '0;
  assign w_act    = r_pend & r_en;
  assign w_ack    = intr_ack && r_st == ASP_IRQ_REQ;
  assign w_id_oh  = NUM_LINES'(1) << r_id;
  assign w_inc    = 4'(r_id) + 4'd1;
  assign w_rdata  = csr_address == ASP_IRQ_CSR_PENDING ? 64'(r_pend) :
                    csr_address == ASP_IRQ_CSR_ENABLE  ? 64'(r_en)   :
                    csr_address == ASP_IRQ_CSR_ACTIVE  ? 64'(w_act)  :
                    csr_address == ASP_IRQ_CSR_COUNT   ? 64'(w_cnt)  : 64'd0;
  asp_irq_rr_arbiter #(.N(NUM_LINES), .W(2)) u_arb (
    .i_req  (w_act),
    .i_ptr  (r_ptr),
    .o_idx  (w_idx),
    .o_valid(w_sel_valid)
  );
  always_ff @(posedge clk) begin
    if (reset) r_st <= ASP_IRQ_IDLE;
    else r_st <= w_st_nxt;
  end
  // WAIT_CLR holds off any new request until the signalled line is cleared or masked
  always_comb begin
    w_st_nxt = r_st == ASP_IRQ_IDLE ? (w_sel_valid ? ASP_IRQ_REQ : ASP_IRQ_IDLE) :
               r_st == ASP_IRQ_REQ  ? (intr_ack ? ASP_IRQ_WAIT_CLR : ASP_IRQ_REQ) :
               (|(w_act & w_id_oh) ? ASP_IRQ_WAIT_CLR : ASP_IRQ_IDLE);
  end
  always_comb begin
    intr_req = r_st == ASP_IRQ_REQ;
    intr_id  = r_id;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq   <= '0;
      r_irq_d <= '0;
      r_pend  <= '0;
      r_en    <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_rdata <= '0;
      r_rdv   <= 1'b0;
    end else begin
      r_irq   <= irq_in & USED;
      r_irq_d <= r_irq;
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      if (w_wr && csr_address == ASP_IRQ_CSR_ENABLE) r_en <= csr_writedata[NUM_LINES-1:0] & USED;
      if (r_st == ASP_IRQ_IDLE && w_sel_valid) r_id <= w_idx;
      if (w_ack) r_ptr <= w_inc >= 4'(NUM_USED) ? 2'd0 : w_inc[1:0];
      r_rdv <= csr_read;
      if (csr_read) r_rdata <= w_rdata;
    end
  end
`ifdef ASP_IRQ_CTRL_COUNTERS_EN
  logic [31:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (w_wr && csr_address == ASP_IRQ_CSR_COUNT) r_cnt <= '0;
    else if (w_ack && ~&r_cnt) r_cnt <= r_cnt + 32'd1;
  end
  assign w_cnt = r_cnt;
`else
  assign w_cnt = '0;
`endif
  assign csr_readdata      = r_rdata;
  assign csr_readdatavalid = r_rdv;
  assign csr_waitrequest   = 1'b0;
endmodule

// File: tb/tb_asp_irq_ctrl.sv
// tb_asp_irq_ctrl: directed bench for asp_irq_ctrl with a cycle model and literal spot checks.
module tb_asp_irq_ctrl;
  import ofs_asp_pkg::*;
  localparam int NL = ASP_NUM_INTERRUPT_LINES;
  localparam int NU = ASP_NUM_IRQ_USED;
  localparam int USED = (1 << NU) - 1;
  logic          clk, reset, csr_read, csr_write, csr_readdatavalid, csr_waitrequest;
  logic          intr_req, intr_ack;
  logic [NL-1:0] irq_in;
  logic [2:0]    csr_address;
  logic [63:0]   csr_writedata, csr_readdata;
  logic [7:0]    csr_byteenable;
  logic [1:0]    intr_id;
  int            n_vec, n_err;
  bit            started;

  asp_irq_ctrl #(.NUM_LINES(ASP_NUM_INTERRUPT_LINES), .NUM_USED(ASP_NUM_IRQ_USED)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .csr_address(csr_address),
    .csr_read(csr_read), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .csr_byteenable(csr_byteenable), .csr_readdata(csr_readdata),
    .csr_readdatavalid(csr_readdatavalid), .csr_waitrequest(csr_waitrequest),
    .intr_req(intr_req), .intr_id(intr_id), .intr_ack(intr_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cb(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  // Behavioural model: sets of lines as integer masks, FSM as a mode number.
  int          m_reg, m_prev, m_pend, m_en, m_mode, m_id, m_ptr;
  bit          m_rdv;
  logic [63:0] m_rdata;
  longint      m_cnt;

  function automatic logic [63:0] m_csr(input int a);
    case (a)
      0: return 64'(m_pend);
      1: return 64'(m_en);
      2: return 64'(m_pend & m_en);
`ifdef ASP_IRQ_CTRL_COUNTERS_EN
      3: return 64'(m_cnt);
`endif
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int rise, clr, act, wd;
    bit wr;
    started = 1'b1;
    if (reset) begin
      m_reg = 0; m_prev = 0; m_pend = 0; m_en = 0; m_mode = 0; m_id = 0; m_ptr = 0;
      m_rdv = 1'b0; m_rdata = 64'd0; m_cnt = 0;
    end else begin
      wr   = csr_write && csr_byteenable[0];
      wd   = int'(csr_writedata[NL-1:0]);
      act  = m_pend & m_en;
      rise = m_reg & ~m_prev;
      clr  = (wr && csr_address == 3'd0) ? wd : 0;
      m_rdv = csr_read;
      if (csr_read) m_rdata = m_csr(int'(csr_address));
      if (m_mode == 0) begin
        if (act != 0) begin
          for (int k = NU - 1; k >= 0; k--)
            if (((act >> ((m_ptr + k) % NU)) & 1) != 0) m_id = (m_ptr + k) % NU;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (intr_ack) begin
          m_ptr = (m_id + 1) % NU;
          m_mode = 2;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
      end else if (((act >> m_id) & 1) == 0) m_mode = 0;
      if (wr && csr_address == 3'd3) m_cnt = 0;
      if (wr && csr_address == 3'd1) m_en = wd & USED;
      m_pend = ((m_pend & ~clr) | rise) & USED;
      m_prev = m_reg;
      m_reg  = int'(irq_in) & USED;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      cb("intr_req", intr_req, m_mode == 1);
      chk("intr_id", 64'(intr_id), 64'(m_id));
      cb("waitrequest", csr_waitrequest, 1'b0);
      cb("readdatavalid", csr_readdatavalid, m_rdv);
      if (m_rdv) chk("readdata", csr_readdata, m_rdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [63:0] d, input logic [7:0] be = 8'h01);
    csr_address = a; csr_writedata = d; csr_byteenable = be; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [63:0] exp, input string name);
    csr_address = a; csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    cb({name, " valid"}, csr_readdatavalid, 1'b1);
    chk(name, csr_readdata, exp);
  endtask

  task automatic wait_req(input logic [1:0] exp_id, input string name);
    int i = 0;
    while (!intr_req && i < 12) begin
      @(negedge clk);
      i++;
    end
    cb({name, " req"}, intr_req, 1'b1);
    chk({name, " id"}, 64'(intr_id), 64'(exp_id));
  endtask

  task automatic ack();
    intr_ack = 1'b1;
    @(negedge clk);
    intr_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; csr_address = 3'd0; csr_read = 1'b0; csr_write = 1'b0;
    csr_writedata = 64'd0; csr_byteenable = 8'h00; intr_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    cb("rst intr_req", intr_req, 1'b0);
    rd(3'd0, 64'h0, "rst pending");
    rd(3'd1, 64'h0, "rst enable");
    rd(3'd2, 64'h0, "rst active");
    rd(3'd3, 64'h0, "rst count");
    rd(3'd5, 64'h0, "unmapped 5");
    // single kernel interrupt through the whole handshake
    wr(3'd1, 64'h7);
    rd(3'd1, 64'h7, "enable");
    irq_in = 4'b0010;
    tick(2);
    cb("t27 early", intr_req, 1'b0);
    tick(1);
    cb("t27 req", intr_req, 1'b1);
    chk("t27 id", 64'(intr_id), 64'd1);
    rd(3'd0, 64'h2, "t27 pending");
    ack();
    cb("t27 wait_clr", intr_req, 1'b0);
    rd(3'd2, 64'h2, "t27 active");
    wr(3'd0, 64'h2);
    tick(1);
    rd(3'd0, 64'h0, "t27 cleared");
    ack();
    tick(3);
    cb("t27 no reissue", intr_req, 1'b0);
    irq_in = 4'b0000;
    // round robin between DMA_0 and DMA_1
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    wr(3'd1, 64'h7);
    irq_in = 4'b0101;
    tick(3);
    cb("t28 first req", intr_req, 1'b1);
    chk("t28 first id", 64'(intr_id), 64'd0);
    ack();
    wr(3'd0, 64'h1);
    wait_req(2'd2, "t28 second");
    ack();
    wr(3'd0, 64'h4);
    irq_in = 4'b0000;
    tick(3);
    irq_in = 4'b0101;
    wait_req(2'd0, "t28 ptr wrapped");
    ack();
    wr(3'd0, 64'h5);
    irq_in = 4'b0000;
    tick(3);
    // unused line 3 and byte-enable gating
    wr(3'd1, 64'hF);
    irq_in = 4'b1000;
    tick(4);
    cb("t29 no req", intr_req, 1'b0);
    rd(3'd0, 64'h0, "t29 pending");
    rd(3'd1, 64'h7, "t29 enable masked");
    wr(3'd1, 64'h0, 8'hFE);
    rd(3'd1, 64'h7, "be0 low ignored");
    wr(3'd6, 64'hFF);
    rd(3'd6, 64'h0, "unmapped 6");
    irq_in = 4'b0000;
    // set beats a simultaneous W1C
    wr(3'd1, 64'h0);
    irq_in = 4'b0001;
    tick(1);
    wr(3'd0, 64'h1);
    rd(3'd0, 64'h1, "t30 set wins");
    wr(3'd0, 64'h1);
    rd(3'd0, 64'h0, "t30 cleared");
    irq_in = 4'b0000;
    // masking while requesting keeps the request until ack
    wr(3'd1, 64'h7);
    irq_in = 4'b0001;
    wait_req(2'd0, "t31");
    wr(3'd1, 64'h0);
    tick(3);
    cb("t31 held", intr_req, 1'b1);
    ack();
    tick(4);
    cb("t31 no reissue", intr_req, 1'b0);
    rd(3'd0, 64'h1, "t31 pending kept");
    wr(3'd0, 64'h1);
    irq_in = 4'b0000;
    // ack counting
    wr(3'd3, 64'h0);
    wr(3'd1, 64'h7);
    for (int i = 0; i < 5; i++) begin
      irq_in = 4'b0010;
      wait_req(2'd1, "t32 loop");
      ack();
      wr(3'd0, 64'h2);
      irq_in = 4'b0000;
      tick(3);
    end
`ifdef ASP_IRQ_CTRL_COUNTERS_EN
    rd(3'd3, 64'h5, "t32 count");
    wr(3'd3, 64'h1234);
    rd(3'd3, 64'h0, "t32 count cleared");
`else
    rd(3'd3, 64'h0, "count absent");
`endif
    // reset in the middle of a request and a read
    irq_in = 4'b0010;
    wait_req(2'd1, "t32 pre-reset");
    csr_address = 3'd1;
    csr_read = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    cb("reset drops req", intr_req, 1'b0);
    cb("reset kills rdv", csr_readdatavalid, 1'b0);
    reset = 1'b0;
    tick(3);
    cb("post reset idle", intr_req, 1'b0);
    irq_in = 4'b0000;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
